// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between the instruction
// fetch port and the load/store data port. Grants are combinational, data
// beats fetch, and read data returns one cycle after the grant to whichever
// port owned that access.
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to add a fetch starvation
// counter. When it reaches MAX_WAIT, fetch wins over data for one cycle.
// Without the macro, data has strict priority.
//
// Handshake: a requester holds req and its fields stable until it sees gnt
// (or d_err for the data port) in the same cycle. Each grant issues exactly
// one RAM command. A read grant in cycle N returns rvalid in cycle N+1.
// Stores never return rvalid.
module mem_arbiter #(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    // instruction fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    // load/store port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_size,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    // RAM command (word addressed)
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-3:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    // debug visibility of internal state
    output logic [1:0]    dbg_rsp_sel,
    output logic [3:0]    dbg_wait_cnt
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_IF   = 2'd1,
        RSP_D    = 2'd2
    } rsp_sel_e;

    rsp_sel_e    rsp_sel_q;
    rsp_sel_e    rsp_sel_d;
    logic        d_misalign;
    logic        d_legal;
    logic        if_force;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    // The low address bits of a fetch are ignored, because fetches are word aligned.
    logic unused_if_addr_lsb;
    assign unused_if_addr_lsb = ^if_addr[1:0];

    // Detect data requests whose size/alignment combination the RAM cannot serve.
    always_comb begin
        d_misalign = 1'b0;
        case (d_size)
            2'd0:    d_misalign = 1'b0;
            2'd1:    d_misalign = d_addr[0];
            2'd2:    d_misalign = (d_addr[1:0] != 2'b00);
            default: d_misalign = 1'b1;
        endcase
    end

    assign d_legal = d_req && !d_misalign && !reset;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    assign if_force     = if_req && (wait_cnt_q == WAIT_LIMIT);
    assign dbg_wait_cnt = wait_cnt_q;

    // Count consecutive cycles in which fetch asks but is refused.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!if_req || if_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'hF) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = ^(4'(MAX_WAIT));
    assign if_force        = 1'b0;
    assign dbg_wait_cnt    = 4'd0;
`endif

    // Grant decision: data first unless the starvation guard forces fetch.
    // Reset suppresses all grants.
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        d_err  = 1'b0;
        if (!reset) begin
            d_err = d_req && d_misalign;
            if (d_legal && !if_force) begin
                d_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
    end

    // Build store byte strobes and the lane-replicated write data from the size field.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = d_wdata;
        case (d_size)
            2'd0: begin
                st_be    = 4'b0001 << d_addr[1:0];
                st_wdata = {4{d_wdata[7:0]}};
            end
            2'd1: begin
                st_be    = 4'b0011 << d_addr[1:0];
                st_wdata = {2{d_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = d_wdata;
            end
        endcase
    end

    // Drive the single RAM command from whichever port was granted. Idle drives zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en   = 1'b1;
            mem_addr = d_addr[AW-1:2];
            if (d_we) begin
                mem_we    = st_be;
                mem_wdata = st_wdata;
            end
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[AW-1:2];
        end
    end

    // Choose which port owns next cycle's read data. Stores produce no response.
    always_comb begin
        rsp_sel_d = RSP_NONE;
        if (d_gnt && !d_we) begin
            rsp_sel_d = RSP_D;
        end else if (if_gnt) begin
            rsp_sel_d = RSP_IF;
        end
    end

    // Response owner register. Reset drops any pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_sel_q <= RSP_NONE;
        end else begin
            rsp_sel_q <= rsp_sel_d;
        end
    end

    assign if_rdata    = mem_rdata;
    assign d_rdata     = mem_rdata;
    assign if_rvalid   = (rsp_sel_q == RSP_IF) && !reset;
    assign d_rvalid    = (rsp_sel_q == RSP_D) && !reset;
    assign dbg_rsp_sel = rsp_sel_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It contains:
//   - a RAM environment model,
//   - a byte-level reference memory,
//   - an arbitration model derived from the priority rules,
//   - expected-response queues for each port.
// Directed scenarios run first, followed by randomized traffic.
module tb_mem_arbiter;
  localparam int AW       = 16;
  localparam int MAX_WAIT = 4;
  localparam int WORDS    = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          d_err;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic [1:0]    dbg_rsp_sel;
  logic [3:0]    dbg_wait_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [7:0]  model_mem [1 << AW];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_d_q[$];
  int          m_cnt = 0;

  // environment RAM, separate from the model
  logic [31:0] ram [WORDS];

  // clock / reset block
  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .if_req       (if_req),
    .if_addr      (if_addr),
    .if_gnt       (if_gnt),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_size       (d_size),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_gnt        (d_gnt),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .dbg_rsp_sel  (dbg_rsp_sel),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // synchronous RAM: registered read, byte-enabled write
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      for (int i = 0; i < 4; i++) begin
        if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [AW-1:0] a);
    int base;
    base = int'({a[AW-1:2], 2'b00});
    return {model_mem[base+3], model_mem[base+2], model_mem[base+1], model_mem[base]};
  endfunction

  // per-cycle scoreboard: predict this cycle's outputs from the current inputs
  task automatic model_check();
    int          n;
    int          off;
    bit          bad;
    bit          d_ok;
    bit          force_if;
    bit          e_if;
    bit          e_d;
    bit          e_err;
    logic [3:0]  e_we;
    logic [31:0] e_wd;
    logic [AW-3:0] e_addr;
    logic [31:0] exp_v;

    if (reset) begin
      exp_if_q.delete();
      exp_d_q.delete();
      m_cnt = 0;
      check("rst_if_gnt", if_gnt, 0);
      check("rst_d_gnt", d_gnt, 0);
      check("rst_d_err", d_err, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_if_rvalid", if_rvalid, 0);
      check("rst_d_rvalid", d_rvalid, 0);
      return;
    end

    case (d_size)
      2'd0:    n = 1;
      2'd1:    n = 2;
      2'd2:    n = 4;
      default: n = 0;
    endcase
    if (n == 0) bad = 1'b1;
    else        bad = ((int'(d_addr) % n) != 0);
    d_ok = d_req && !bad;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_if = if_req && (m_cnt == MAX_WAIT);
`else
    force_if = 1'b0;
`endif
    e_d   = d_ok && !force_if;
    e_if  = if_req && !e_d;
    e_err = d_req && bad;

    e_we   = 4'b0000;
    e_wd   = 32'h0;
    e_addr = '0;
    off    = int'(d_addr[1:0]);
    if (e_d) begin
      e_addr = d_addr[AW-1:2];
      if (d_we) begin
        for (int b = 0; b < 4; b++) begin
          e_we[b] = (b >= off) && (b < off + n);
          e_wd[8*b +: 8] = d_wdata[8*(b % n) +: 8];
        end
      end
    end else if (e_if) begin
      e_addr = if_addr[AW-1:2];
    end

    check("if_gnt", if_gnt, e_if);
    check("d_gnt", d_gnt, e_d);
    check("d_err", d_err, e_err);
    check("mem_en", mem_en, e_d || e_if);
    check("mem_addr", mem_addr, e_addr);
    check("mem_we", mem_we, e_we);
    if ((e_d && d_we) || !(e_d || e_if)) check("mem_wdata", mem_wdata, e_wd);

    check("if_rvalid", if_rvalid, exp_if_q.size() != 0);
    if (exp_if_q.size() != 0) begin
      exp_v = exp_if_q.pop_front();
      check("if_rdata", if_rdata, exp_v);
    end
    check("d_rvalid", d_rvalid, exp_d_q.size() != 0);
    if (exp_d_q.size() != 0) begin
      exp_v = exp_d_q.pop_front();
      check("d_rdata", d_rdata, exp_v);
    end

    if (e_if) exp_if_q.push_back(model_word(if_addr));
    if (e_d && !d_we) exp_d_q.push_back(model_word(d_addr));
    if (e_d && d_we) begin
      for (int k = 0; k < n; k++) model_mem[int'(d_addr) + k] = d_wdata[8*k +: 8];
    end
    if (if_req && !e_if) m_cnt++;
    else                 m_cnt = 0;
  endtask

  // driver tasks
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input bit we, input logic [1:0] sz, input logic [AW-1:0] a,
                          input logic [31:0] wd);
    d_req   = 1'b1;
    d_we    = we;
    d_size  = sz;
    d_addr  = a;
    d_wdata = wd;
  endtask

  int first_gnt;
  bit held_if;
  bit held_d;

  initial begin
    logic [31:0] v;
    reset = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'd0; d_addr = '0; d_wdata = '0;
    for (int w = 0; w < WORDS; w++) begin
      v = $urandom;
      if (w == 4) v = 32'h0050_0093;
      ram[w] = v;
      for (int b = 0; b < 4; b++) model_mem[4*w + b] = v[8*b +: 8];
    end

    repeat (2) begin sample(); advance(); end
    reset = 1'b0;

    // fetch from word 4
    if_req = 1'b1; if_addr = 16'h0010;
    sample();
    check("t1_if_gnt", if_gnt, 1);
    check("t1_mem_addr", mem_addr, 14'h0004);
    advance();
    if_req = 1'b0;
    sample();
    check("t1_if_rvalid", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    advance();

    // contested: data load wins, fetch follows
    if_req = 1'b1; if_addr = 16'h0020;
    set_data(1'b0, 2'd2, 16'h0104, 32'h0);
    sample();
    check("t2_d_gnt", d_gnt, 1);
    check("t2_if_gnt", if_gnt, 0);
    advance();
    d_req = 1'b0;
    sample();
    check("t2_d_rvalid", d_rvalid, 1);
    check("t2_if_gnt_next", if_gnt, 1);
    advance();
    if_req = 1'b0;
    sample();
    advance();

    // byte store into lane 3
    set_data(1'b1, 2'd0, 16'h0203, 32'h0000_00AB);
    sample();
    check("t3_mem_we", mem_we, 4'b1000);
    check("t3_mem_wdata", mem_wdata, 32'hABAB_ABAB);
    check("t3_mem_addr", mem_addr, 14'h0080);
    advance();
    d_req = 1'b0;
    sample();
    check("t3_no_rvalid", d_rvalid, 0);
    advance();

    // misaligned half store alongside fetch
    if_req = 1'b1; if_addr = 16'h0030;
    set_data(1'b1, 2'd1, 16'h0201, 32'h0000_1234);
    sample();
    check("t4_d_err", d_err, 1);
    check("t4_d_gnt", d_gnt, 0);
    check("t4_mem_we", mem_we, 4'b0000);
    check("t4_if_gnt", if_gnt, 1);
    advance();
    d_req = 1'b0; if_req = 1'b0;
    sample();
    advance();

    // starvation: load held continuously with fetch pending
    if_req = 1'b1; if_addr = 16'h0040;
    set_data(1'b0, 2'd2, 16'h0108, 32'h0);
    first_gnt = -1;
    for (int c = 1; c <= 12; c++) begin
      sample();
      if (if_gnt && first_gnt < 0) first_gnt = c;
`ifdef MEM_ARB_STARVE_GUARD_EN
      if (first_gnt > 0 && c == first_gnt + 1) check("t5_data_resumes", d_gnt, 1);
`endif
      advance();
      if (first_gnt == c) if_req = 1'b0;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("t5_first_if_gnt", first_gnt, MAX_WAIT + 1);
`else
    check("t5_first_if_gnt", first_gnt, -1);
`endif
    d_req = 1'b0; if_req = 1'b0;
    sample(); advance();

    // reset right after a load grant
    set_data(1'b0, 2'd2, 16'h0110, 32'h0);
    sample();
    check("t6_d_gnt", d_gnt, 1);
    advance();
    d_req = 1'b0; reset = 1'b1;
    sample();
    check("t6_rst_d_rvalid", d_rvalid, 0);
    check("t6_rst_mem_en", mem_en, 0);
    advance();
    reset = 1'b0;
    sample();
    check("t6_post_d_rvalid", d_rvalid, 0);
    advance();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      sample();
      held_if = if_req && !if_gnt;
      held_d  = d_req && !d_gnt && !d_err;
      advance();
      reset = ($urandom_range(0, 199) == 0);
      if (!held_if) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = AW'($urandom_range(0, 'h3FF));
      end
      if (!held_d) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        d_addr  = AW'($urandom_range(0, 'h3FF));
        d_wdata = $urandom;
      end
    end

    reset = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (2) begin sample(); advance(); end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter that shares one synchronous RAM between the CPU instruction-fetch port and the load/store data port. It accepts one request per cycle, grants by fixed data-over-fetch priority with an optional starvation guard, and routes the 1-cycle-latency read data back to whichever requester was granted. It sits between `CPU` and the unified memory model, replacing the separate ROM/RAM split for the single-memory build.

## Interface
- `AW`, 16: byte-address width.
- `MAX_WAIT`, 4: consecutive cycles fetch may be denied before forced grant (guard build only); range 1..15.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in AW: fetch byte address; word-aligned, `[1:0]` ignored.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid; exactly 1 cycle after `if_gnt`.
- `if_rdata` out 32: fetched instruction.
- `d_req` in 1: data request; held with fields stable until `d_gnt` or `d_err`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 2: 0 byte, 1 half, 2 word; 3 illegal.
- `d_addr` in AW: data byte address.
- `d_wdata` in 32: store data, LSB-justified.
- `d_gnt` out 1: data request accepted.
- `d_rvalid` out 1: load data valid, 1 cycle after `d_gnt` with `d_we`=0; never for stores.
- `d_rdata` out 32: load word (raw, unshifted; CPU does extension).
- `d_err` out 1: 1-cycle pulse, misaligned or illegal-size request rejected.
- `mem_en` out 1, `mem_we` out 4, `mem_addr` out AW-2, `mem_wdata` out 32: RAM command, word address.
- `mem_rdata` in 32: RAM read data, registered, valid 1 cycle after `mem_en`.

## Operation
- Combinational grant each cycle; one memory command per cycle; no request queue.
- Data check first: misaligned if `d_size`=1 and `d_addr[0]`, `d_size`=2 and `d_addr[1:0]`≠0, or `d_size`=3. Misaligned → `d_err`=1 that cycle, no `d_gnt`, no memory access; fetch may still be granted the same cycle.
- Legal `d_req` wins over `if_req`; fetch granted only when no legal data request.
- Store: `mem_we` = byte strobes shifted by `d_addr[1:0]` (byte `4'b0001<<a`, half `4'b0011<<a`, word `4'b1111`); `mem_wdata` = `d_wdata` replicated into lanes (byte ×4, half ×2).
- Load/fetch: `mem_en`=1, `mem_we`=0.
- Response owner register `rsp_sel` (NONE/IF/D) captured at grant; next cycle drives `mem_rdata` to `if_rdata` or `d_rdata` and pulses matching `rvalid`. `rsp_sel`=D only for loads.
- `if_rdata`/`d_rdata` both wired to `mem_rdata` continuously; only `rvalid` is qualified.
- Idle: `mem_en`=0, `mem_we`=0, address/wdata don't-care (driven 0).

## Timing
- Reset values: `rsp_sel`=NONE, starvation counter 0, all `*_gnt`, `*_rvalid`, `d_err`, `mem_en`, `mem_we` = 0.
- Latency request→grant: 0 cycles when uncontested; read data: grant cycle +1.
- Back-to-back grants every cycle allowed; response of cycle N coexists with grant of cycle N+1.
- Reset asserted mid-operation: pending response dropped, no `rvalid` in the cycle after reset; requesters re-issue.
- `if_req` and `d_req` with `d_err`: fetch granted same cycle.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined: 4-bit counter increments each cycle `if_req`=1 and not granted, clears on `if_gnt` or `if_req`=0; when counter = `MAX_WAIT`, fetch wins over a legal data request for that cycle (data gets no `d_gnt`, holds).
- Undefined: counter absent; strict data priority, fetch may starve indefinitely.

## Test plan
- Reset then `if_req`, `if_addr`=0x0010, RAM word 4 = 0x00500093 → `if_gnt`, `mem_addr`=4 same cycle; next cycle `if_rvalid`=1, `if_rdata`=0x00500093.
- Simultaneous `if_req` and load `d_addr`=0x0104 word → `d_gnt`=1, `if_gnt`=0; next cycle `d_rvalid`=1; following cycle `if_gnt`=1.
- Store byte 0xAB at `d_addr`=0x0203 → `mem_we`=4'b1000, `mem_wdata`=0xABABABAB, `mem_addr`=0x80; no `d_rvalid`.
- Half store `d_addr`=0x0201 with `if_req` → `d_err` pulse, `mem_we`=0, `if_gnt`=1 same cycle.
- Guard on, `MAX_WAIT`=4, `d_req` load held continuously with `if_req` → `if_gnt` first at 5th cycle, then data resumes; guard off → `if_gnt` never while `d_req` high.
- Reset asserted the cycle after a load grant → no `d_rvalid` next cycle, all outputs 0.
